// File: rtl/counter_updn_param_pkg.sv
// Package: counter_updn_param_pkg
// Shared definitions for the parametrised up/down counter family.
//   DIR_UP / DIR_DOWN    : encoding of the Dir input
//   MODE_WRAP / MODE_SAT : legal values of the SATURATE parameter
//   params_ok()          : elaboration-time sanity check of a parameter set
`timescale 1ns/1ps
package counter_updn_param_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // True when the parameter set describes a legal counter.
    // WIDTH is limited to 31 bits so that MAX_VAL stays a positive int.
    function automatic bit params_ok(input int width, input int max_val,
                                     input int saturate, input int reset_val);
        longint span;
        span = longint'(1) << width;
        return (width >= 1) && (width <= 31) &&
               (max_val >= 0) && (longint'(max_val) < span) &&
               (reset_val >= 0) && (reset_val <= max_val) &&
               ((saturate == MODE_WRAP) || (saturate == MODE_SAT));
    endfunction

endpackage

// File: rtl/counter_next_val.sv
// Module: counter_next_val
// Combinational single-step successor of the count, honouring the modulus
// and the wrap/saturate mode.
//   cur      in   WIDTH  current count
//   dir      in   1      DIR_UP or DIR_DOWN
//   nxt      out  WIDTH  count after one step
//   wrap_evt out  1      the step crossed a limit and wrapped
//   sat_evt  out  1      the step was blocked at a limit
`timescale 1ns/1ps
module counter_next_val
    import counter_updn_param_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             dir,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap_evt,
    output logic             sat_evt
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        nxt      = cur;
        wrap_evt = 1'b0;
        sat_evt  = 1'b0;

        if (dir == DIR_UP) begin
            // '>=' also pulls an out-of-range value (illegal RESET_VAL)
            // back into range instead of counting further up.
            if (cur >= MAX_V) begin
                if (SATURATE == MODE_SAT) begin
                    sat_evt = 1'b1;
                end else begin
                    nxt      = '0;
                    wrap_evt = 1'b1;
                end
            end else begin
                nxt = cur + 1'b1;
            end
        end else begin
            if (cur == '0) begin
                if (SATURATE == MODE_SAT) begin
                    sat_evt = 1'b1;
                end else begin
                    nxt      = MAX_V;
                    wrap_evt = 1'b1;
                end
            end else begin
                nxt = cur - 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_updn_param.sv
// Module: counter_updn_param
// Parametrised up/down counter with count enable, synchronous clear,
// clamped parallel load and wrap-or-saturate behaviour at 0 / MAX_VAL.
//   clk      in   1      rising-edge clock
//   Reset    in   1      asynchronous, active-high reset to RESET_VAL
//   En       in   1      count one step per clock while high
//   Dir      in   1      1 = up, 0 = down
//   Clear    in   1      synchronous clear to RESET_VAL (highest priority)
//   Load     in   1      synchronous load of LoadVal (clamped to MAX_VAL)
//   LoadVal  in   WIDTH  value captured on Load
//   Output   out  WIDTH  current count
//   AtMax    out  1      Output == MAX_VAL
//   AtMin    out  1      Output == 0
//   Wrap     out  1      registered pulse: last edge wrapped
//   Sat      out  1      registered pulse: last edge was blocked at a limit
`timescale 1ns/1ps
module counter_updn_param
    import counter_updn_param_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = (1 << WIDTH) - 1,
    parameter int SATURATE  = MODE_WRAP,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    input  logic             Clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    output logic [WIDTH-1:0] Output,
    output logic             AtMax,
    output logic             AtMin,
    output logic             Wrap,
    output logic             Sat
);

    if (!params_ok(WIDTH, MAX_VAL, SATURATE, RESET_VAL)) begin : g_bad_params
        $error("counter_updn_param: illegal parameter set");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] step_nxt;
    logic             step_wrap;
    logic             step_sat;

    counter_next_val #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .cur      (Output),
        .dir      (Dir),
        .nxt      (step_nxt),
        .wrap_evt (step_wrap),
        .sat_evt  (step_sat)
    );

    logic [WIDTH-1:0] cnt_d;
    logic             wrap_d;
    logic             sat_d;

    // Priority: Clear > Load > En > hold. Event flags only come from a step.
    always_comb begin
        cnt_d  = Output;
        wrap_d = 1'b0;
        sat_d  = 1'b0;
        if (Clear) begin
            cnt_d = RST_V;
        end else if (Load) begin
            cnt_d = (LoadVal > MAX_V) ? MAX_V : LoadVal;
        end else if (En) begin
            cnt_d  = step_nxt;
            wrap_d = step_wrap;
            sat_d  = step_sat;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            Output <= RST_V;
            Wrap   <= 1'b0;
            Sat    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            Output <= cnt_d;
            Wrap   <= wrap_d;
            Sat    <= sat_d;
        end
    end

    assign AtMax = (Output == MAX_V);
    assign AtMin = (Output == '0);

endmodule

// File: tb/tb_counter_updn_param.sv
// Testbench: tb_counter_updn_param
// Four counter configurations share one stimulus stream:
//   0: WIDTH=4 MAX_VAL=9  wrap       RESET_VAL=0
//   1: WIDTH=4 MAX_VAL=9  saturate   RESET_VAL=3
//   2: WIDTH=8 MAX_VAL=255 wrap      RESET_VAL=0
//   3: WIDTH=1 MAX_VAL=1  wrap       RESET_VAL=0
// Each is compared with an arithmetic reference model every cycle, plus
// directed expectations for the notable scenarios.
`timescale 1ns/1ps
module tb_counter_updn_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       Reset;
    logic       En;
    logic       Dir;
    logic       Clear;
    logic       Load;
    logic [7:0] ldv;

    logic [3:0] q_w;
    logic [3:0] q_s;
    logic [7:0] q_b;
    logic [0:0] q_t;
    logic [3:0] at_max;
    logic [3:0] at_min;
    logic [3:0] wr;
    logic [3:0] st;

    counter_updn_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .RESET_VAL(0)) u_w (
        .clk(clk), .Reset(Reset), .En(En), .Dir(Dir), .Clear(Clear), .Load(Load),
        .LoadVal(ldv[3:0]), .Output(q_w), .AtMax(at_max[0]), .AtMin(at_min[0]),
        .Wrap(wr[0]), .Sat(st[0]));

    counter_updn_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .RESET_VAL(3)) u_s (
        .clk(clk), .Reset(Reset), .En(En), .Dir(Dir), .Clear(Clear), .Load(Load),
        .LoadVal(ldv[3:0]), .Output(q_s), .AtMax(at_max[1]), .AtMin(at_min[1]),
        .Wrap(wr[1]), .Sat(st[1]));

    counter_updn_param #(.WIDTH(8), .SATURATE(0)) u_b (
        .clk(clk), .Reset(Reset), .En(En), .Dir(Dir), .Clear(Clear), .Load(Load),
        .LoadVal(ldv), .Output(q_b), .AtMax(at_max[2]), .AtMin(at_min[2]),
        .Wrap(wr[2]), .Sat(st[2]));

    counter_updn_param #(.WIDTH(1)) u_t (
        .clk(clk), .Reset(Reset), .En(En), .Dir(Dir), .Clear(Clear), .Load(Load),
        .LoadVal(ldv[0:0]), .Output(q_t), .AtMax(at_max[3]), .AtMin(at_min[3]),
        .Wrap(wr[3]), .Sat(st[3]));

    localparam int MAXV [4] = '{9, 9, 255, 1};
    localparam int WID  [4] = '{4, 4, 8, 1};
    localparam int SATM [4] = '{0, 1, 0, 0};
    localparam int RSTV [4] = '{0, 3, 0, 0};

    int m_cnt  [4];
    bit m_wrap [4];
    bit m_sat  [4];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_q(input int i);
        case (i)
            0:       return 32'(q_w);
            1:       return 32'(q_s);
            2:       return 32'(q_b);
            default: return 32'(q_t);
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = RSTV[i];
            m_wrap[i] = 1'b0;
            m_sat[i]  = 1'b0;
        end
    endfunction

    // Reference: counting is arithmetic on an integer in 0..MAXV; stepping
    // outside that range either wraps modulo MAXV+1 or is refused.
    function automatic void model_edge(input bit c, input bit l, input bit e,
                                       input bit d, input int v);
        for (int i = 0; i < 4; i++) begin
            int lv;
            int tgt;
            m_wrap[i] = 1'b0;
            m_sat[i]  = 1'b0;
            if (c) begin
                m_cnt[i] = RSTV[i];
            end else if (l) begin
                lv       = v % (1 << WID[i]);
                m_cnt[i] = (lv > MAXV[i]) ? MAXV[i] : lv;
            end else if (e) begin
                tgt = m_cnt[i] + (d ? 1 : -1);
                if (tgt < 0 || tgt > MAXV[i]) begin
                    if (SATM[i] != 0) begin
                        m_sat[i] = 1'b1;
                    end else begin
                        m_cnt[i]  = (tgt + MAXV[i] + 1) % (MAXV[i] + 1);
                        m_wrap[i] = 1'b1;
                    end
                end else begin
                    m_cnt[i] = tgt;
                end
            end
        end
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s u%0d count", tag, i), obs_q(i), 32'(m_cnt[i]));
            check($sformatf("%s u%0d atmax", tag, i), 32'(at_max[i]), 32'(m_cnt[i] == MAXV[i]));
            check($sformatf("%s u%0d atmin", tag, i), 32'(at_min[i]), 32'(m_cnt[i] == 0));
            check($sformatf("%s u%0d wrap", tag, i), 32'(wr[i]), 32'(m_wrap[i]));
            check($sformatf("%s u%0d sat", tag, i), 32'(st[i]), 32'(m_sat[i]));
        end
    endtask

    // Drive one edge's worth of inputs, advance the model, sample 1ns after the edge.
    task automatic edge_step(input bit c, input bit l, input bit e, input bit d,
                             input int v, input string tag);
        Clear = c;
        Load  = l;
        En    = e;
        Dir   = d;
        ldv   = 8'(v);
        model_edge(c, l, e, d, v);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        Reset = 1'b1;
        En    = 1'b0;
        Dir   = 1'b1;
        Clear = 1'b0;
        Load  = 1'b0;
        ldv   = '0;
        model_reset();
        #2;
        check_all("reset");
        check("reset u_s value", 32'(q_s), 32'd3);

        @(negedge clk);
        Reset = 1'b0;

        // Count up 0..9,0,1,2; single-bit instance toggles.
        for (int k = 1; k <= 12; k++) begin
            edge_step(1'b0, 1'b0, 1'b1, 1'b1, 0, "up");
            check($sformatf("up%0d q_w", k), 32'(q_w), 32'(k % 10));
            check($sformatf("up%0d wrap", k), 32'(wr[0]), 32'(k == 10));
            check($sformatf("up%0d q_t", k), 32'(q_t), 32'(k % 2));
        end

        // Down from 0 wraps to MAX, then an oversized load clamps.
        edge_step(1'b1, 1'b0, 1'b0, 1'b0, 0, "clr");
        edge_step(1'b0, 1'b0, 1'b1, 1'b0, 0, "down_wrap");
        check("down_wrap q_w", 32'(q_w), 32'd9);
        check("down_wrap wrap", 32'(wr[0]), 32'd1);
        check("down_wrap atmax", 32'(at_max[0]), 32'd1);
        edge_step(1'b0, 1'b1, 1'b0, 1'b0, 15, "clamp");
        check("clamp q_w", 32'(q_w), 32'd9);

        // Saturation at the top, then release downwards.
        edge_step(1'b0, 1'b1, 1'b0, 1'b0, 9, "load9");
        for (int k = 0; k < 3; k++) begin
            edge_step(1'b0, 1'b0, 1'b1, 1'b1, 0, "sat_hold");
            check("sat_hold q_s", 32'(q_s), 32'd9);
            check("sat_hold sat", 32'(st[1]), 32'd1);
        end
        edge_step(1'b0, 1'b0, 1'b1, 1'b0, 0, "sat_rel");
        check("sat_rel q_s", 32'(q_s), 32'd8);
        check("sat_rel sat", 32'(st[1]), 32'd0);

        // Priority: Clear beats Load beats En.
        edge_step(1'b1, 1'b1, 1'b1, 1'b1, 5, "prio_clr");
        check("prio_clr q_w", 32'(q_w), 32'd0);
        edge_step(1'b0, 1'b1, 1'b1, 1'b1, 5, "prio_ld");
        check("prio_ld q_w", 32'(q_w), 32'd5);

        // 8-bit default modulus wraps at 255.
        edge_step(1'b0, 1'b1, 1'b0, 1'b1, 254, "ld254");
        edge_step(1'b0, 1'b0, 1'b1, 1'b1, 0, "b255");
        check("b255 q_b", 32'(q_b), 32'd255);
        edge_step(1'b0, 1'b0, 1'b1, 1'b1, 0, "b0");
        check("b0 q_b", 32'(q_b), 32'd0);
        check("b0 wrap", 32'(wr[2]), 32'd1);
        edge_step(1'b0, 1'b0, 1'b0, 1'b1, 0, "bhold");
        check("bhold q_b", 32'(q_b), 32'd0);
        check("bhold wrap", 32'(wr[2]), 32'd0);

        // Random traffic with an asynchronous reset dropped in mid-count.
        for (int n = 0; n < 300; n++) begin
            if (n == 150) begin
                #($urandom_range(1, 6));
                Reset = 1'b1;
                model_reset();
                #1;
                check_all("async_rst");
                check("async_rst q_w", 32'(q_w), 32'd0);
                @(posedge clk);
                #1;
                check_all("rst_held");
                Reset = 1'b0;
                edge_step(1'b0, 1'b0, 1'b1, 1'b1, 0, "resume");
                check("resume q_w", 32'(q_w), 32'd1);
            end
            edge_step($urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      int'($urandom_range(0, 255)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
